apb_s_err: RTL and testbench

- APB slave register block with wait states and error response.
- Consumes one select line (psel1 or psel2) plus the shared penable/paddr/pwdata/pwrite from the APB master.
- Returns prdata, pready and pslverr to that master.
- Holds an RW register file plus two read-only status counters; flags illegal accesses via pslverr.

---
 rtl/apb_s_err_if.sv | 22 ++
 rtl/apb_s_err.sv | 137 +++++++++++++
 tb/tb_apb_s_err.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_s_err_if.sv
// APB bus bundle between one master and the apb_s_err slave.
// Only the select line for this slave is carried.
interface apb_s_err_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_s_err.sv
// APB slave register block with wait states and error response: RW byte
// registers, then saturating WR_CNT and ERR_CNT status counters.
module apb_s_err #(
  parameter int unsigned RW_DEPTH = 10,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic         pclk,
  input  logic         presetn,
  apb_s_err_if.slave   apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam logic [4:0] WrCntAddr  = 5'(RW_DEPTH);
  localparam logic [4:0] ErrCntAddr = 5'(RW_DEPTH + 1);
  localparam logic [2:0] WaitLoad   = 3'(WAIT_CYC);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] addr_q, addr_d;
  logic       write_q, write_d;
  logic [7:0] wdata_q, wdata_d;
  logic       proterr_q, proterr_d;

  logic [7:0] regs_q [RW_DEPTH];
  logic [7:0] wrcnt_q, errcnt_q;

  logic       ready, err, commit, errInc, load;
  logic [4:0] addrExt;
  logic [7:0] rdVal;

  assign addrExt = {1'b0, addr_q};
  assign ready   = (state_q == ACCESS) && (cnt_q == 3'd0);

  // A skipped setup phase poisons the transfer regardless of what was latched.
  assign err     = proterr_q || (addrExt > ErrCntAddr) ||
                   (write_q && (addrExt >= WrCntAddr));
  assign commit  = ready && write_q && !err;
  assign errInc  = ready && err;

  always_comb begin
    rdVal = 8'h00;
    for (int i = 0; i < int'(RW_DEPTH); i++) begin
      if (addrExt == 5'(i)) rdVal = regs_q[i];
    end
    if (addrExt == WrCntAddr)  rdVal = wrcnt_q;
    if (addrExt == ErrCntAddr) rdVal = errcnt_q;
  end

  assign apb.pready  = ready;
  assign apb.pslverr = ready && err;
  assign apb.prdata  = (ready && !err && !write_q) ? rdVal : 8'h00;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    proterr_d = proterr_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = SETUP;
        end else if (apb.psel && apb.penable) begin
          state_d   = ACCESS;
          load      = 1'b1;
          proterr_d = 1'b1;
        end
      end
      SETUP: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (apb.penable) begin
          state_d   = ACCESS;
          load      = 1'b1;
          proterr_d = 1'b0;
        end
      end
      ACCESS: begin
        // The completing cycle hands control back as if we were idle,
        // so a master can present its next setup phase right away.
        if (ready) begin
          if (apb.psel && !apb.penable) begin
            state_d = SETUP;
          end else if (apb.psel && apb.penable) begin
            state_d   = ACCESS;
            load      = 1'b1;
            proterr_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    addr_d  = load ? apb.paddr  : addr_q;
    write_d = load ? apb.pwrite : write_q;
    wdata_d = load ? apb.pwdata : wdata_q;
    if (load) cnt_d = WaitLoad;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 4'd0;
      write_q   <= 1'b0;
      wdata_q   <= 8'h00;
      proterr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      proterr_q <= proterr_d;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(RW_DEPTH); i++) regs_q[i] <= 8'h00;
      wrcnt_q  <= 8'h00;
      errcnt_q <= 8'h00;
    end else begin
      for (int i = 0; i < int'(RW_DEPTH); i++) begin
        if (commit && (addrExt == 5'(i))) regs_q[i] <= wdata_q;
      end
      if (commit && (wrcnt_q != 8'hFF))  wrcnt_q  <= wrcnt_q + 8'd1;
      if (errInc && (errcnt_q != 8'hFF)) errcnt_q <= errcnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_s_err.sv
// Directed self-checking bench for apb_s_err: dut0 runs with two wait
// states, dut1 with zero wait states for back-to-back traffic.
module tb_apb_s_err;

  logic pclk = 1'b0;
  logic presetn;
  int   errors = 0;
  int   checks = 0;
  int   idleLeak = 0;

  apb_s_err_if bus0();
  apb_s_err_if bus1();

  apb_s_err #(.RW_DEPTH(10), .WAIT_CYC(2)) dut0 (.pclk(pclk), .presetn(presetn), .apb(bus0));
  apb_s_err #(.RW_DEPTH(10), .WAIT_CYC(0)) dut1 (.pclk(pclk), .presetn(presetn), .apb(bus1));

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge, outputs are sampled on the falling edge.
  task automatic drive(input int d, input logic s, input logic e, input logic w,
                       input logic [3:0] a, input logic [7:0] wd);
    if (d == 0) begin
      bus0.psel = s; bus0.penable = e; bus0.pwrite = w; bus0.paddr = a; bus0.pwdata = wd;
    end else begin
      bus1.psel = s; bus1.penable = e; bus1.pwrite = w; bus1.paddr = a; bus1.pwdata = wd;
    end
  endtask

  function automatic logic [9:0] outs(input int d);
    if (d == 0) return {bus0.pready, bus0.pslverr, bus0.prdata};
    return {bus1.pready, bus1.pslverr, bus1.prdata};
  endfunction

  task automatic idle_cycles(input int d, input int k);
    drive(d, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (k) @(negedge pclk);
  endtask

  // Returns at the falling edge of the completing cycle with the bus still
  // driven, so the next call presents its setup phase back to back.
  task automatic do_xfer(input int d, input logic wr, input logic [3:0] a, input logic [7:0] wd,
                         input bit skipSetup, input int abortAt,
                         output logic [7:0] rd, output logic err, output int cyc, output bit got);
    logic [9:0] o;
    int n;
    rd = 8'h00; err = 1'b0; cyc = 0; got = 1'b0; n = 0;
    if (!skipSetup) begin
      drive(d, 1'b1, 1'b0, wr, a, wd);
      @(negedge pclk);
    end
    drive(d, 1'b1, 1'b1, wr, a, wd);
    while (!got && n < 20) begin
      @(negedge pclk);
      n++;
      o = outs(d);
      if (o[9]) begin
        got = 1'b1; cyc = n; err = o[8]; rd = o[7:0];
      end else begin
        if (o[8:0] != 9'd0) idleLeak++;
        if (abortAt == n) begin
          drive(d, 1'b0, 1'b0, wr, a, wd);
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (3) @(negedge pclk);
    checks++;
    if (outs(0) !== 10'd0) begin errors++; $display("[TB] FAIL reset_outs0: got %h expected 000", outs(0)); end
    checks++;
    if (outs(1) !== 10'd0) begin errors++; $display("[TB] FAIL reset_outs1: got %h expected 000", outs(1)); end
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_write_read();
    logic [7:0] rd; logic err; int cyc; bit got;
    do_xfer(0, 1'b1, 4'd3, 8'hA5, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (!got || cyc !== 3 || err !== 1'b0) begin errors++;
      $display("[TB] FAIL wr3_timing: got ready=%0d cycles=%0d err=%0d expected 1/3/0", got, cyc, err); end
    do_xfer(0, 1'b0, 4'd3, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (!got || cyc !== 3 || err !== 1'b0 || rd !== 8'hA5) begin errors++;
      $display("[TB] FAIL rd3: got ready=%0d cycles=%0d err=%0d data=%h expected 1/3/0/a5", got, cyc, err, rd); end
    do_xfer(0, 1'b0, 4'd10, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (!got || err !== 1'b0 || rd !== 8'h01) begin errors++;
      $display("[TB] FAIL wrcnt_after_one: got err=%0d data=%h expected 0/01", err, rd); end
    idle_cycles(0, 2);
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic err; int cyc; bit got;
    do_xfer(0, 1'b0, 4'd15, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (!got || cyc !== 3 || err !== 1'b1 || rd !== 8'h00) begin errors++;
      $display("[TB] FAIL rd15_err: got ready=%0d cycles=%0d err=%0d data=%h expected 1/3/1/00", got, cyc, err, rd); end
    do_xfer(0, 1'b1, 4'd10, 8'h11, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (!got || err !== 1'b1 || rd !== 8'h00) begin errors++;
      $display("[TB] FAIL wr_wrcnt_err: got err=%0d data=%h expected 1/00", err, rd); end
    do_xfer(0, 1'b0, 4'd10, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (err !== 1'b0 || rd !== 8'h01) begin errors++;
      $display("[TB] FAIL wrcnt_unchanged: got err=%0d data=%h expected 0/01", err, rd); end
    do_xfer(0, 1'b0, 4'd11, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (err !== 1'b0 || rd !== 8'h02) begin errors++;
      $display("[TB] FAIL errcnt_two: got err=%0d data=%h expected 0/02", err, rd); end
    idle_cycles(0, 2);
  endtask

  task automatic test_protocol_error();
    logic [7:0] rd; logic err; int cyc; bit got;
    do_xfer(0, 1'b1, 4'd0, 8'h77, 1'b1, 0, rd, err, cyc, got);
    checks++;
    if (!got || cyc !== 3 || err !== 1'b1) begin errors++;
      $display("[TB] FAIL noset_wr0: got ready=%0d cycles=%0d err=%0d expected 1/3/1", got, cyc, err); end
    idle_cycles(0, 2);
    do_xfer(0, 1'b0, 4'd0, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (err !== 1'b0 || rd !== 8'h00) begin errors++;
      $display("[TB] FAIL noset_reg0: got err=%0d data=%h expected 0/00", err, rd); end
    do_xfer(0, 1'b0, 4'd11, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (rd !== 8'h03) begin errors++;
      $display("[TB] FAIL noset_errcnt: got %h expected 03", rd); end
    idle_cycles(0, 2);
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic err; int cyc; bit got; int readySeen;
    do_xfer(0, 1'b1, 4'd5, 8'h3C, 1'b0, 2, rd, err, cyc, got);
    checks++;
    if (got !== 1'b0) begin errors++;
      $display("[TB] FAIL abort_ready: got ready=%0d expected 0", got); end
    readySeen = 0;
    repeat (4) begin
      @(negedge pclk);
      if (outs(0) !== 10'd0) readySeen++;
    end
    checks++;
    if (readySeen !== 0) begin errors++;
      $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", readySeen); end
    do_xfer(0, 1'b0, 4'd5, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("[TB] FAIL abort_reg5: got %h expected 00", rd); end
    do_xfer(0, 1'b0, 4'd10, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("[TB] FAIL abort_wrcnt: got %h expected 01", rd); end
    do_xfer(0, 1'b1, 4'd5, 8'h5A, 1'b0, 0, rd, err, cyc, got);
    do_xfer(0, 1'b0, 4'd5, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (!got || err !== 1'b0 || rd !== 8'h5A) begin errors++;
      $display("[TB] FAIL after_abort_rd5: got err=%0d data=%h expected 0/5a", err, rd); end
    idle_cycles(0, 2);
  endtask

  task automatic test_saturation();
    logic [7:0] rd; logic err; int cyc; bit got; int bad;
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      do_xfer(0, 1'b1, 4'(i % 10), 8'(i), 1'b0, 0, rd, err, cyc, got);
      if (!got || err !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL sat_writes: got %0d bad transfers expected 0", bad); end
    do_xfer(0, 1'b0, 4'd10, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (rd !== 8'hFF) begin errors++; $display("[TB] FAIL wrcnt_sat: got %h expected ff", rd); end
    do_xfer(0, 1'b0, 4'd0, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (rd !== 8'hFA) begin errors++; $display("[TB] FAIL sat_reg0: got %h expected fa", rd); end
    do_xfer(0, 1'b0, 4'd9, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (rd !== 8'h03) begin errors++; $display("[TB] FAIL sat_reg9: got %h expected 03", rd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; logic err; int cyc; bit got;
    do_xfer(0, 1'b0, 4'd10, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (!got || rd !== 8'hFF) begin errors++;
      $display("[TB] FAIL pre_reset_rd: got ready=%0d data=%h expected 1/ff", got, rd); end
    #1 presetn = 1'b0;
    #1;
    checks++;
    if (outs(0) !== 10'd0) begin errors++;
      $display("[TB] FAIL mid_reset_outs: got %h expected 000", outs(0)); end
    idle_cycles(0, 2);
    presetn = 1'b1;
    @(negedge pclk);
    for (int a = 0; a < 12; a++) begin
      do_xfer(0, 1'b0, 4'(a), 8'h00, 1'b0, 0, rd, err, cyc, got);
      checks++;
      if (!got || err !== 1'b0 || rd !== 8'h00) begin errors++;
        $display("[TB] FAIL post_reset_addr%0d: got err=%0d data=%h expected 0/00", a, err, rd); end
    end
    idle_cycles(0, 2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic err; int cyc; bit got;
    for (int i = 0; i < 10; i++) begin
      do_xfer(1, 1'b1, 4'(i), 8'(8'h10 + 7 * i), 1'b0, 0, rd, err, cyc, got);
      checks++;
      if (!got || cyc !== 1 || err !== 1'b0) begin errors++;
        $display("[TB] FAIL b2b_wr%0d: got ready=%0d cycles=%0d err=%0d expected 1/1/0", i, got, cyc, err); end
    end
    for (int i = 0; i < 10; i++) begin
      do_xfer(1, 1'b0, 4'(i), 8'h00, 1'b0, 0, rd, err, cyc, got);
      checks++;
      if (!got || cyc !== 1 || rd !== 8'(8'h10 + 7 * i)) begin errors++;
        $display("[TB] FAIL b2b_rd%0d: got cycles=%0d data=%h expected 1/%h", i, cyc, rd, 8'(8'h10 + 7 * i)); end
    end
    do_xfer(1, 1'b0, 4'd10, 8'h00, 1'b0, 0, rd, err, cyc, got);
    checks++;
    if (rd !== 8'h0A) begin errors++; $display("[TB] FAIL b2b_wrcnt: got %h expected 0a", rd); end
    idle_cycles(1, 2);
    checks++;
    if (idleLeak !== 0) begin errors++;
      $display("[TB] FAIL quiet_when_not_ready: got %0d leaking cycles expected 0", idleLeak); end
  endtask

  initial begin
    $display("[TB] starting apb_s_err bench");
    test_reset();
    test_write_read();
    test_errors();
    test_protocol_error();
    test_abort();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
